alu_muldiv_seq: RTL and testbench
=================================

// Module: alu_muldiv_seq
// PURPOSE
//  Multi-cycle sequencer adding RV32M multiply/divide support to the single-cycle core
//  without a second adder: it drives the shared 32-bit ALU with ADD/SUB each cycle.
//  Shift-add multiply and restoring divide run one bit per cycle.
//  Sits beside the ALU; the core stalls on busy and the ALU input mux selects this block while busy=1.
// PARAMETERS
//  ALU_OP_ADD  5'b00000  ALU op code driven for add steps and when idle
//  ALU_OP_SUB  5'b00001  ALU op code driven for subtract/negate steps
//  N_ITER      32        iteration count (= data width; fixed at 32)
// PORTS
//  clk       in   1   rising-edge clock
//  rst_n     in   1   asynchronous reset, active-low
//  start     in   1   request; accepted only in IDLE
//  op        in   3   funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  rs1       in   32  dividend / multiplier
//  rs2       in   32  divisor / multiplicand
//  busy      out  1   high in every state except IDLE
//  done      out  1   one-cycle pulse; result valid this cycle
//  illegal   out  1   pulses with done for unsupported op (001, 010)
//  result    out  32  final value, held until next accepted start
//  alu_a     out  32  ALU operand a
//  alu_b     out  32  ALU operand b
//  alu_op    out  5   ALU operation
//  alu_res   in   32  ALU result (combinational, same cycle)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy=0, done=0, illegal=0, result=0; internal regs=0;
//   alu_a=alu_b=0, alu_op=ALU_OP_ADD. Reset mid-operation aborts; no done pulse.
//  FSM: IDLE, NEG_A, NEG_B, ITER, FIX, DONE. Counter cnt: 5 bits.
//  IDLE: start=1 latches op/rs1/rs2 and selects the next state:
//   - fast path -> DONE: op 001/010 (result 0, illegal=1);
//     divisor 0 (DIV/DIVU -> 32'hFFFFFFFF, REM/REMU -> rs1);
//     DIV/REM with rs1=32'h80000000, rs2=32'hFFFFFFFF (DIV -> 32'h80000000, REM -> 0).
//   - DIV/REM -> NEG_A. MUL, MULHU, DIVU, REMU -> ITER with cnt=0.
//  NEG_A / NEG_B: 1 cycle each, always entered for DIV/REM.
//   ALU computes SUB(0, x); the magnitude of rs1 (then rs2) is stored.
//   The stored value is the negation if x[31]=1, else x unchanged.
//   neg_q = rs1[31]^rs2[31]; neg_r = rs1[31].
//  ITER (multiply): alu_a=hi, alu_b=lo[0]?mcand:0, ADD; carry=(alu_res<hi) unsigned;
//   {hi,lo} <= {carry, alu_res, lo[31:1]}; hi starts at 0, lo starts at rs1.
//  ITER (divide): sh={rem[30:0],quo[31]}; alu_a=sh, alu_b=dvs, SUB;
//   ge = rem[31] | (sh >= dvs); rem <= ge ? alu_res : sh; quo <= {quo[30:0], ge}.
//  ITER exits after exactly 32 cycles (cnt 0..31).
//   Unsigned ops -> DONE; DIV/REM -> FIX.
//  FIX: 1 cycle. If the sign flag for the selected output is set, the value is negated via ALU SUB(0,v); else passed through.
//  DONE: result registered on entry. done=1 for this single cycle.
//   Next state is IDLE. busy is still 1 in DONE.
//  Result selection: MUL=lo, MULHU=hi, DIVU/DIV=quo, REMU/REM=rem (after FIX).
//  Latency, counted from the start edge to the cycle where done=1: fast path 1; unsigned 33; DIV/REM 36.
//  start while busy=1 is ignored, including the DONE cycle; back-to-back issue is possible from the cycle after DONE.
//  When the ALU is not in use (IDLE, DONE), drive alu_a=0, alu_b=0, alu_op=ALU_OP_ADD.
//  All arithmetic is 32-bit modular. Carry and compare logic are local; every add and subtract goes through the ALU.
// TESTING
//  MUL rs1=7, rs2=6 -> done at +33 cycles, result=42; MULHU 32'hFFFFFFFF x 32'hFFFFFFFF -> 32'hFFFFFFFE.
//  DIVU 100/7 -> 14 at +33; REMU 100/7 -> 2; DIV -7/2 -> 32'hFFFFFFFD at +36; REM -7/2 -> 32'hFFFFFFFF.
//  Divisor 0: DIVU 5/0 -> 32'hFFFFFFFF, REM 5/0 -> 5, both with done at +1 and illegal=0.
//  DIV 32'h80000000 / 32'hFFFFFFFF -> 32'h80000000 at +1; op=001 -> result 0, illegal=1 at +1.
//  Issue start during busy (cycle +10) -> ignored, first result unchanged.
//   New start on the cycle after DONE -> accepted.
//  Drop rst_n at ITER cycle 15 -> busy=0, done=0, result=0 immediately.
//   A new DIVU 9/3 then returns 3.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer that borrows the core's shared ALU
// for every add/subtract: shift-add multiply and restoring divide, one bit per cycle.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; ALU driven to ADD(0,0)
// NEG_A | signed divide: replace dividend with its magnitude
// NEG_B | signed divide: replace divisor with its magnitude
// ITER  | one multiply or divide bit per cycle, cnt counts 0..31
// FIX   | signed divide: apply quotient/remainder sign
// DONE  | result valid, done pulse, back to IDLE

module alu_muldiv_seq #(
    parameter logic [4:0] ALU_OP_ADD = 5'b00000,
    parameter logic [4:0] ALU_OP_SUB = 5'b00001,
    parameter int         N_ITER     = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [31:0] result,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    input  logic [31:0] alu_res
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NEG_A,
        S_NEG_B,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [4:0] CNT_LAST = 5'(N_ITER - 1);

    state_t      state, state_nxt;
    logic [2:0]  op_q, op_nxt;
    logic [31:0] hi, hi_nxt;      // product high half / partial remainder
    logic [31:0] lo, lo_nxt;      // product low half (multiplier) / quotient (dividend)
    logic [31:0] mcand, mcand_nxt; // multiplicand / divisor
    logic [4:0]  cnt, cnt_nxt;
    logic        neg_q, neg_q_nxt;
    logic        neg_r, neg_r_nxt;
    logic        ill_q, ill_nxt;
    logic [31:0] result_q, result_nxt;

    logic [31:0] sh;
    logic        ge;
    logic        carry;
    logic [31:0] fix_v;
    logic        fix_neg;
    logic        op_illegal;
    logic        op_signed_div;

    assign op_illegal    = ~op[2] & (op[1] ^ op[0]);
    assign op_signed_div = op[2] & ~op[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= 3'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            mcand    <= 32'd0;
            cnt      <= 5'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            ill_q    <= 1'b0;
            result_q <= 32'd0;
        end else begin
            op_q     <= op_nxt;
            hi       <= hi_nxt;
            lo       <= lo_nxt;
            mcand    <= mcand_nxt;
            cnt      <= cnt_nxt;
            neg_q    <= neg_q_nxt;
            neg_r    <= neg_r_nxt;
            ill_q    <= ill_nxt;
            result_q <= result_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        op_nxt     = op_q;
        hi_nxt     = hi;
        lo_nxt     = lo;
        mcand_nxt  = mcand;
        cnt_nxt    = cnt;
        neg_q_nxt  = neg_q;
        neg_r_nxt  = neg_r;
        ill_nxt    = ill_q;
        result_nxt = result_q;
        alu_a      = 32'd0;
        alu_b      = 32'd0;
        alu_op     = ALU_OP_ADD;
        sh         = 32'd0;
        ge         = 1'b0;
        carry      = 1'b0;
        fix_v      = op_q[1] ? hi : lo;
        fix_neg    = op_q[1] ? neg_r : neg_q;

        case (state)
            S_IDLE: begin
                if (start) begin
                    op_nxt    = op;
                    hi_nxt    = 32'd0;
                    lo_nxt    = rs1;
                    mcand_nxt = rs2;
                    cnt_nxt   = 5'd0;
                    neg_q_nxt = rs1[31] ^ rs2[31];
                    neg_r_nxt = rs1[31];
                    ill_nxt   = 1'b0;
                    if (op_illegal) begin
                        ill_nxt    = 1'b1;
                        result_nxt = 32'd0;
                        state_nxt  = S_DONE;
                    end else if (op[2] && rs2 == 32'd0) begin
                        result_nxt = op[1] ? rs1 : 32'hFFFF_FFFF;
                        state_nxt  = S_DONE;
                    end else if (op_signed_div && rs1 == 32'h8000_0000 && rs2 == 32'hFFFF_FFFF) begin
                        result_nxt = op[1] ? 32'd0 : 32'h8000_0000;
                        state_nxt  = S_DONE;
                    end else if (op_signed_div) begin
                        state_nxt = S_NEG_A;
                    end else begin
                        state_nxt = S_ITER;
                    end
                end
            end

            S_NEG_A: begin
                alu_b  = lo;
                alu_op = ALU_OP_SUB;
                if (lo[31]) begin
                    lo_nxt = alu_res;
                end
                state_nxt = S_NEG_B;
            end

            S_NEG_B: begin
                alu_b  = mcand;
                alu_op = ALU_OP_SUB;
                if (mcand[31]) begin
                    mcand_nxt = alu_res;
                end
                state_nxt = S_ITER;
            end

            S_ITER: begin
                cnt_nxt = cnt + 5'd1;
                if (!op_q[2]) begin
                    alu_a  = hi;
                    alu_b  = lo[0] ? mcand : 32'd0;
                    alu_op = ALU_OP_ADD;
                    carry  = (alu_res < hi);
                    hi_nxt = {carry, alu_res[31:1]};
                    lo_nxt = {alu_res[0], lo[31:1]};
                end else begin
                    // rem[31] set means the shifted value had a 33rd bit, so it always fits
                    sh     = {hi[30:0], lo[31]};
                    alu_a  = sh;
                    alu_b  = mcand;
                    alu_op = ALU_OP_SUB;
                    ge     = hi[31] | (sh >= mcand);
                    hi_nxt = ge ? alu_res : sh;
                    lo_nxt = {lo[30:0], ge};
                end
                if (cnt == CNT_LAST) begin
                    if (op_q[2] && !op_q[0]) begin
                        state_nxt = S_FIX;
                    end else begin
                        result_nxt = op_q[1] ? hi_nxt : lo_nxt;
                        state_nxt  = S_DONE;
                    end
                end
            end

            S_FIX: begin
                alu_b      = fix_v;
                alu_op     = ALU_OP_SUB;
                result_nxt = fix_neg ? alu_res : fix_v;
                state_nxt  = S_DONE;
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign illegal = done & ill_q;
    assign result  = result_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized self-checking bench for alu_muldiv_seq; the shared ALU and the
// expected RV32M results come from plain arithmetic in the bench.

module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic        busy, done, illegal;
    logic [31:0] result, alu_a, alu_b, alu_res;
    logic [4:0]  alu_op;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_res = 32'd0;

    alu_muldiv_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs1     (rs1),
        .rs2     (rs2),
        .busy    (busy),
        .done    (done),
        .illegal (illegal),
        .result  (result),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_op  (alu_op),
        .alu_res (alu_res)
    );

    always #5 clk = ~clk;

    assign alu_res = (alu_op == 5'd1) ? alu_a - alu_b :
                     (alu_op == 5'd0) ? alu_a + alu_b : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic ill, output int lat);
        longint unsigned p;
        int              sa, sb;
        logic            ovf;
        p   = 64'(a) * 64'(b);
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        ill = 1'b0;
        res = 32'd0;
        lat = 33;
        case (o)
            3'd0: res = p[31:0];
            3'd3: res = p[63:32];
            3'd1, 3'd2: begin ill = 1'b1; lat = 1; end
            3'd4: begin
                if (b == 32'd0) begin res = 32'hFFFF_FFFF; lat = 1; end
                else if (ovf) begin res = 32'h8000_0000; lat = 1; end
                else begin res = 32'(sa / sb); lat = 36; end
            end
            3'd5: begin
                if (b == 32'd0) begin res = 32'hFFFF_FFFF; lat = 1; end
                else res = a / b;
            end
            3'd6: begin
                if (b == 32'd0) begin res = a; lat = 1; end
                else if (ovf) begin res = 32'd0; lat = 1; end
                else begin res = 32'(sa % sb); lat = 36; end
            end
            default: begin
                if (b == 32'd0) begin res = a; lat = 1; end
                else res = a % b;
            end
        endcase
    endtask

    // inject > 1: pulse start at that cycle while busy; poke: hold start during DONE
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inject, input bit poke, input string tag);
        logic [31:0] exp_res;
        logic        exp_ill;
        int          exp_lat;
        int          n;
        @(negedge clk);
        check({tag, "/idle_busy"}, 32'(busy), 32'd0);
        check({tag, "/idle_alu_a"}, alu_a, 32'd0);
        check({tag, "/idle_alu_b"}, alu_b, 32'd0);
        check({tag, "/idle_alu_op"}, 32'(alu_op), 32'd0);
        check({tag, "/hold"}, result, last_res);
        model(o, a, b, exp_res, exp_ill, exp_lat);
        start = 1'b1;
        op    = o;
        rs1   = a;
        rs2   = b;
        n     = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k != inject) start = 1'b0;
            if (k == 1) begin
                op  = 3'($urandom);
                rs1 = $urandom;
                rs2 = $urandom;
            end
            if (done) begin
                n = k;
                break;
            end
            if (k == inject) begin
                start = 1'b1;
                op    = 3'($urandom);
                rs1   = $urandom;
                rs2   = $urandom;
            end
        end
        if (n == 0) begin
            check({tag, "/timeout"}, 32'(done), 32'd1);
        end else begin
            check({tag, "/latency"}, 32'(n), 32'(exp_lat));
            check({tag, "/result"}, result, exp_res);
            check({tag, "/illegal"}, 32'(illegal), 32'(exp_ill));
            check({tag, "/busy_done"}, 32'(busy), 32'd1);
        end
        if (poke) begin
            start = 1'b1;
            op    = 3'($urandom);
            rs1   = $urandom;
            rs2   = $urandom;
            @(negedge clk);
            start = 1'b0;
            check({tag, "/done_ignored"}, 32'(busy), 32'd0);
            check({tag, "/done_pulse"}, 32'(done), 32'd0);
        end
        last_res = exp_res;
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int          sel;

        repeat (3) @(negedge clk);
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/done", 32'(done), 32'd0);
        check("rst/illegal", 32'(illegal), 32'd0);
        check("rst/result", result, 32'd0);
        check("rst/alu_a", alu_a, 32'd0);
        check("rst/alu_b", alu_b, 32'd0);
        check("rst/alu_op", 32'(alu_op), 32'd0);
        rst_n = 1'b1;

        run_op(3'd0, 32'd7, 32'd6, 0, 1'b0, "mul_7x6");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, "mulhu_max");
        run_op(3'd5, 32'd100, 32'd7, 0, 1'b0, "divu_100_7");
        run_op(3'd7, 32'd100, 32'd7, 0, 1'b0, "remu_100_7");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, "div_m7_2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, "rem_m7_2");
        run_op(3'd5, 32'd5, 32'd0, 0, 1'b0, "divu_by0");
        run_op(3'd6, 32'd5, 32'd0, 0, 1'b0, "rem_by0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, "rem_ovf");
        run_op(3'd1, 32'd3, 32'd4, 0, 1'b0, "mulh_illegal");
        run_op(3'd2, 32'd3, 32'd4, 0, 1'b0, "mulhsu_illegal");
        run_op(3'd0, 32'd123, 32'd456, 10, 1'b1, "busy_ignore");
        run_op(3'd4, 32'd1000, 32'hFFFF_FFFD, 10, 1'b0, "div_busy_ignore");
        run_op(3'd5, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, "back_to_back");

        // abort in the middle of a divide
        @(negedge clk);
        start = 1'b1;
        op    = 3'd5;
        rs1   = 32'd1234567;
        rs2   = 32'd89;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("abort/busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort/busy", 32'(busy), 32'd0);
        check("abort/done", 32'(done), 32'd0);
        check("abort/result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_res = 32'd0;
        run_op(3'd5, 32'd9, 32'd3, 0, 1'b0, "divu_after_rst");

        for (int i = 0; i < 60; i++) begin
            ro  = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if (sel == 2) rb = 32'($urandom_range(1, 15));
            if (sel == 3) ra = 32'($urandom_range(0, 255));
            if (sel == 6) rb = -32'($urandom_range(1, 15));
            run_op(ro, ra, rb, (sel == 4) ? $urandom_range(2, 30) : 0, sel == 5, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
